// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU bus responder with a TX FIFO and
// a divisor-timed serialiser. Bit period is DIVISOR clocks; irq flags a drained transmitter.
module mmio_uart_tx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int DEFAULT_DIV = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sel,
    input  logic [13:0] addr,
    input  logic        ren,
    output logic [31:0] rdata,
    input  logic        wen,
    input  logic [31:0] wdata,
    input  logic [1:0]  wsize,
    output logic        tx,
    output logic        irq
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_t;

    tx_state_t          state;
    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               overflow;
    logic [15:0]        divisor;
    logic [15:0]        div_lat;
    logic [15:0]        bit_cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shifter;

    logic               wr_acc;
    logic               rd_acc;
    logic [1:0]         reg_idx;
    logic               fifo_empty;
    logic               fifo_full;
    logic               busy;
    logic               pop;
    logic               push_req;
    logic               push;
    logic               ovf_set;
    logic               shift_en;
    logic [31:0]        rd_mux;
    logic               unused_bus;

    // A zero divisor would stall the bit counter, so it is clamped to one.
    function automatic logic [15:0] clamp_div(input logic [15:0] value);
        return (value == 16'd0) ? 16'd1 : value;
    endfunction

    assign wr_acc     = sel & wen;
    assign rd_acc     = sel & ren;
    assign reg_idx    = addr[3:2];
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_FULL);
    assign busy       = (state != S_IDLE);
    assign pop        = (state == S_IDLE) && !fifo_empty;
    assign push_req   = wr_acc && (reg_idx == REG_DATA);
    // A full FIFO still accepts a byte on the edge where the FSM frees a slot.
    assign push       = push_req && (!fifo_full || pop);
    assign ovf_set    = push_req && fifo_full && !pop;
    assign shift_en   = ((state == S_START) || (state == S_DATA)) && (bit_cnt == 16'd0);
    assign irq        = fifo_empty && !busy;
    assign unused_bus = ^{wsize, addr[13:4], addr[1:0], wdata[31:16]};

    always_comb begin
        rd_mux = 32'd0;
        case (reg_idx)
            REG_STATUS: rd_mux = {28'd0, overflow, busy, fifo_full, fifo_empty};
            REG_DIV:    rd_mux = {16'd0, divisor};
            default:    rd_mux = 32'd0;
        endcase
    end

    // Bus register stage: read data lands one edge after the strobe.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata   <= 32'd0;
            divisor <= 16'(DEFAULT_DIV);
        end else begin
            if (rd_acc)
                rdata <= rd_mux;
            if (wr_acc && (reg_idx == REG_DIV))
                divisor <= clamp_div(wdata[15:0]);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (ovf_set)
                overflow <= 1'b1;
            else if (wr_acc && (reg_idx == REG_STATUS) && wdata[3])
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= wdata[7:0];
    end

    // Serialiser datapath: byte and bit period are captured together at pop.
    always_ff @(posedge clk) begin
        if (pop) begin
            shifter <= fifo_mem[rd_ptr];
            div_lat <= divisor;
        end else if (shift_en) begin
            shifter <= {1'b0, shifter[7:1]};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            tx      <= 1'b1;
            bit_cnt <= 16'd0;
            bit_idx <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        tx      <= 1'b0;
                        bit_cnt <= divisor - 16'd1;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_cnt == 16'd0) begin
                        tx      <= shifter[0];
                        bit_cnt <= div_lat - 16'd1;
                        bit_idx <= 3'd0;
                        state   <= S_DATA;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_cnt == 16'd0) begin
                        bit_cnt <= div_lat - 16'd1;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            tx      <= shifter[0];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_cnt == 16'd0)
                        state <= S_IDLE;
                    else
                        bit_cnt <= bit_cnt - 16'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-level reference model (start time, divisor, byte
// per accepted write) predicts tx, irq and STATUS; directed cases plus random traffic.
module tb_mmio_uart_tx;

    localparam int DEPTH = 8;
    localparam logic [13:0] A_DATA = 14'h0;
    localparam logic [13:0] A_STAT = 14'h4;
    localparam logic [13:0] A_DIV  = 14'h8;
    localparam logic [13:0] A_R3   = 14'hC;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        sel = 1'b0;
    logic [13:0] addr = '0;
    logic        ren = 1'b0;
    logic [31:0] rdata;
    logic        wen = 1'b0;
    logic [31:0] wdata = '0;
    logic [1:0]  wsize = 2'b11;
    logic        tx;
    logic        irq;

    mmio_uart_tx #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16)) dut (
        .clk(clk), .resetn(resetn), .sel(sel), .addr(addr), .ren(ren),
        .rdata(rdata), .wen(wen), .wdata(wdata), .wsize(wsize),
        .tx(tx), .irq(irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one entry per accepted byte
    int         f_start[$];
    int         f_div[$];
    logic [7:0] f_byte[$];
    logic       ovf_m = 1'b0;
    int         m_div = 16;
    int         falls[$];
    logic       prev_tx = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic logic exp_tx(input int e);
        int k;
        logic [7:0] b;
        for (int i = 0; i < f_start.size(); i++) begin
            if (e >= f_start[i] && e < f_start[i] + 10 * f_div[i]) begin
                k = (e - f_start[i]) / f_div[i];
                b = f_byte[i];
                if (k == 0) return 1'b0;
                if (k == 9) return 1'b1;
                return b[k-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic int last_end();
        if (f_start.size() == 0) return -1000;
        return f_start[f_start.size()-1] + 10 * f_div[f_div.size()-1];
    endfunction

    function automatic int fifo_cnt(input int e);
        int n = 0;
        for (int i = 0; i < f_start.size(); i++)
            if (f_start[i] > e) n++;
        return n;
    endfunction

    function automatic logic busy_m(input int e);
        for (int i = 0; i < f_start.size(); i++)
            if (e >= f_start[i] && e < f_start[i] + 10 * f_div[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic irq_m(input int e);
        for (int i = 0; i < f_start.size(); i++)
            if (f_start[i] + 10 * f_div[i] > e) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] status_m(input int e);
        int n = fifo_cnt(e);
        return {28'd0, ovf_m, busy_m(e), (n == DEPTH), (n == 0)};
    endfunction

    task automatic model_write(input logic [13:0] a, input logic [31:0] d, input int w);
        int n;
        int s;
        logic popping;
        case (a[3:2])
            2'd0: begin
                n = fifo_cnt(w - 1);
                popping = 1'b0;
                for (int i = 0; i < f_start.size(); i++)
                    if (f_start[i] == w) popping = 1'b1;
                if (n < DEPTH || popping) begin
                    s = (last_end() + 1 > w + 1) ? last_end() + 1 : w + 1;
                    f_start.push_back(s);
                    f_div.push_back(m_div);
                    f_byte.push_back(d[7:0]);
                end else begin
                    ovf_m = 1'b1;
                end
            end
            2'd1: if (d[3]) ovf_m = 1'b0;
            2'd2: m_div = (d[15:0] == 16'd0) ? 1 : int'(d[15:0]);
            default: ;
        endcase
    endtask

    task automatic clear_model();
        f_start.delete();
        f_div.delete();
        f_byte.delete();
        ovf_m = 1'b0;
        m_div = 16;
    endtask

    task automatic bus_write(input logic [13:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; wen = 1'b1; wdata = d;
        addr = {10'($urandom), a[3:2], 2'($urandom)};
        wsize = 2'($urandom_range(1, 3));
        @(posedge clk);
        #1;
        model_write(a, d, cyc);
        sel = 1'b0; wen = 1'b0;
    endtask

    task automatic bus_read(input logic [13:0] a, output logic [31:0] d, output int r);
        @(negedge clk);
        sel = 1'b1; ren = 1'b1;
        addr = {10'($urandom), a[3:2], 2'($urandom)};
        @(posedge clk);
        #1;
        d = rdata; r = cyc;
        sel = 1'b0; ren = 1'b0;
    endtask

    task automatic bus_rw(input logic [13:0] a, input logic [31:0] wd, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; ren = 1'b1; wen = 1'b1; wdata = wd;
        addr = {10'($urandom), a[3:2], 2'($urandom)};
        @(posedge clk);
        #1;
        d = rdata;
        model_write(a, wd, cyc);
        sel = 1'b0; ren = 1'b0; wen = 1'b0;
    endtask

    task automatic wait_drain();
        int lim = last_end() + 3;
        while (cyc < lim) @(posedge clk);
        #1;
    endtask

    // Per-cycle line monitor against the model
    always @(posedge clk) begin
        #2;
        if (resetn) begin
            chk("tx", tx, exp_tx(cyc));
            chk("irq", irq, irq_m(cyc));
            if (prev_tx && !tx) falls.push_back(cyc);
            prev_tx = tx;
        end else begin
            prev_tx = 1'b1;
        end
    end

    initial begin
        #800000;
        $display("FAIL timeout: run exceeded its time budget at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        int r;
        int s;
        int nb;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_irq", irq, 1);
        chk("rst_rdata", rdata, 0);
        @(negedge clk);
        resetn = 1'b1;
        bus_read(A_STAT, d, r);
        chk("rst_status", d, 32'h1);
        bus_read(A_DIV, d, r);
        chk("rst_div", d, 32'd16);
        bus_read(A_DATA, d, r);
        chk("data_reads0", d, 0);
        bus_write(A_R3, 32'hFFFF_FFFF);
        bus_read(A_R3, d, r);
        chk("r3_reads0", d, 0);

        // wen without sel, and rdata hold
        bus_read(A_DIV, d, r);
        @(negedge clk);
        wen = 1'b1; addr = A_DIV; wdata = 32'd5;
        @(posedge clk);
        #1 wen = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("rdata_hold", rdata, 32'd16);
        bus_read(A_DIV, d, r);
        chk("nosel_ignored", d, 32'd16);

        // DIV=4, one frame of 0xA5
        bus_write(A_DIV, 32'd4);
        bus_write(A_DATA, 32'hA5);
        repeat (10) @(posedge clk);
        bus_read(A_STAT, d, r);
        chk("t2_busy", d[2], 1);
        chk("t2_status", d, status_m(r - 1));
        chk("t2_irq_low", irq, 0);
        wait_drain();
        chk("t2_irq_done", irq, 1);

        // DIV=1: nine accepted, tenth overflows
        bus_write(A_DIV, 32'd1);
        for (int i = 0; i < 9; i++) bus_write(A_DATA, 32'h10 + i);
        bus_read(A_STAT, d, r);
        chk("t3_full", d[1], 1);
        chk("t3_ovf0", d[3], 0);
        bus_write(A_DATA, 32'hEE);
        bus_read(A_STAT, d, r);
        chk("t3_ovf1", d[3], 1);
        chk("t3_status", d, status_m(r - 1));
        bus_write(A_STAT, 32'h8);
        bus_read(A_STAT, d, r);
        chk("t3_ovf_clr", d[3], 0);
        wait_drain();

        // DIVISOR=0 stores 1; 11-clock start spacing
        bus_write(A_DIV, 32'd0);
        bus_read(A_DIV, d, r);
        chk("t4_div1", d, 32'd1);
        falls.delete();
        bus_write(A_DATA, 32'hFF);
        bus_write(A_DATA, 32'hFF);
        wait_drain();
        chk("t4_nfalls", falls.size(), 2);
        if (falls.size() >= 2) chk("t4_spacing", falls[1] - falls[0], 11);

        // Divisor change mid-frame applies to the next frame
        bus_write(A_DIV, 32'd4);
        falls.delete();
        bus_write(A_DATA, 32'hFF);
        repeat (8) @(posedge clk);
        bus_write(A_DIV, 32'd8);
        bus_write(A_DATA, 32'hFF);
        wait_drain();
        chk("t5_nfalls", falls.size(), 2);
        if (falls.size() >= 2) chk("t5_spacing", falls[1] - falls[0], 41);

        // Simultaneous read and write returns the pre-write value
        bus_rw(A_DIV, 32'd3, d);
        chk("rw_prewrite", d, 32'd8);
        bus_read(A_DIV, d, r);
        chk("rw_postwrite", d, 32'd3);

        // Reset in the middle of a data bit
        bus_write(A_DIV, 32'd4);
        bus_write(A_DATA, 32'h3C);
        bus_write(A_DATA, 32'h81);
        bus_write(A_DATA, 32'h7E);
        s = f_start[f_start.size()-3];
        while (cyc < s + 13) @(posedge clk);
        bus_read(A_DIV, d, r);
        chk("t6_div4", d, 32'd4);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        clear_model();
        #1;
        chk("t6_tx_async", tx, 1);
        chk("t6_irq", irq, 1);
        chk("t6_rdata", rdata, 0);
        @(negedge clk);
        resetn = 1'b1;
        bus_read(A_STAT, d, r);
        chk("t6_status", d, 32'h1);
        bus_read(A_DIV, d, r);
        chk("t6_div16", d, 32'd16);
        repeat (60) @(posedge clk);
        #1 chk("t6_quiet", tx, 1);

        // Random traffic
        for (int it = 0; it < 25; it++) begin
            bus_write(A_DIV, $urandom_range(0, 6));
            nb = $urandom_range(1, 12);
            for (int j = 0; j < nb; j++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                bus_write(A_DATA, $urandom);
                if ($urandom_range(0, 3) == 0) begin
                    bus_read(A_STAT, d, r);
                    chk("rnd_status", d, status_m(r - 1));
                end
            end
            wait_drain();
            bus_read(A_STAT, d, r);
            chk("rnd_drained", d, status_m(r - 1));
            if (ovf_m) bus_write(A_STAT, 32'h8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
